module_control_banco: RTL and testbench

MODULE_CONTROL_BANCO -- requirements
Module: module_control_banco

---
 rtl/module_control_banco_pkg.sv | 13 +
 rtl/module_control_banco_rr_arbitro.sv | 30 +++
 rtl/module_control_banco.sv | 105 ++++++++++
 tb/tb_module_control_banco.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/module_control_banco_pkg.sv
// Shared constants and state encoding for the register-file controller.
package pkg_banco_registros;

  localparam int N  = 32;         // registers in the controlled register file
  localparam int W  = 4;          // data width of each register
  localparam int AW = $clog2(N);  // register-file address width

  typedef enum logic {
    CLEAR = 1'b0,  // zero-sweep of addresses 1..N-1 in progress
    SERVE = 1'b1   // arbitrating and forwarding requester writes
  } state_t;

endpackage

// File: rtl/module_control_banco_rr_arbitro.sv
// Two-input round-robin arbiter. The priority flag moves only when a grant
// is issued, so a requester that keeps waiting is served next.
module module_rr_arbitro_2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  // High when requester 1 was not granted most recently and wins a tie.
  logic prio1;

  // Grants are combinational; a tie goes to whichever side prio1 favours.
  assign grant0 = valid0 & (~valid1 | ~prio1);
  assign grant1 = valid1 & (~valid0 |  prio1);

  // Priority flag: favours requester 0 out of reset, flips toward the loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio1 <= 1'b0;
    end else if (grant0) begin
      prio1 <= 1'b1;
    end else if (grant1) begin
      prio1 <= 1'b0;
    end
  end

endmodule

// File: rtl/module_control_banco.sv
// Register-file write controller: after reset or a clear request it zeroes
// registers 1..N-1, then forwards writes from two round-robin requesters.
// Register 0 is hard-wired zero, so writes aimed at it are accepted and
// dropped.
module module_control_banco
  import pkg_banco_registros::state_t;
  import pkg_banco_registros::CLEAR;
  import pkg_banco_registros::SERVE;
#(
  parameter  int N  = pkg_banco_registros::N,
  parameter  int W  = pkg_banco_registros::W,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          we,
  output logic [AW-1:0] addr_rd,
  output logic [W-1:0]  data_in,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

  state_t        state;
  logic [AW-1:0] counter;
  logic          serving;
  logic          grant0;
  logic          grant1;
  logic [AW-1:0] sel_addr;
  logic [W-1:0]  sel_data;

  // Requests reach the arbiter only when a grant may legally be issued, so
  // every grant is a real handshake and the arbiter priority stays honest.
  assign serving = (state == SERVE) & ~clear_req & ~rst;

  module_rr_arbitro_2 u_arbitro (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid & serving),
    .valid1 (req1_valid & serving),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // busy follows the state but is forced low while reset is held.
  assign busy = (state == CLEAR) & ~rst;

  // Write source for a handshake; at most one grant is ever high.
  assign sel_addr = grant1 ? req1_addr : req0_addr;
  assign sel_data = grant1 ? req1_data : req0_data;

  // State machine with registered register-file write port.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      counter <= FIRST_ADDR;
      we      <= 1'b0;
      addr_rd <= '0;
      data_in <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          we      <= 1'b1;
          addr_rd <= counter;
          data_in <= '0;
          if (counter == LAST_ADDR) begin
            state <= SERVE;
          end else begin
            counter <= counter + FIRST_ADDR;
          end
        end
        SERVE: begin
          we <= 1'b0;
          if (clear_req) begin
            state   <= CLEAR;
            counter <= FIRST_ADDR;
          end else if ((grant0 | grant1) && (sel_addr != '0)) begin
            we      <= 1'b1;
            addr_rd <= sel_addr;
            data_in <= sel_data;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_control_banco.sv
// Self-checking bench for module_control_banco: stimulus pushes expected
// register-file writes into a queue, a monitor pops them as the DUT writes.
module tb_module_control_banco;

  localparam int N  = 32;
  localparam int W  = 4;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_req;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [W-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          we;
  logic [AW-1:0] addr_rd;
  logic [W-1:0]  data_in;
  logic          busy;

  always #5 clk = ~clk;

  module_control_banco #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .we         (we),
    .addr_rd    (addr_rd),
    .data_in    (data_in),
    .busy       (busy)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  wr_t           exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [W-1:0]  rf[N];          // register file driven by the DUT write port
  int            last_gnt = 1;   // model: requester granted most recently
  bit            pend[2];
  logic [AW-1:0] paddr[2];
  logic [W-1:0]  pdata[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model arbitration: lone requester wins, a tie goes to the other side.
  function automatic int model_grant(input bit v0, input bit v1);
    if (v0 && v1) return 1 - last_gnt;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic apply(input bit clr);
    req0_valid = pend[0];
    req0_addr  = paddr[0];
    req0_data  = pdata[0];
    req1_valid = pend[1];
    req1_addr  = paddr[1];
    req1_data  = pdata[1];
    clear_req  = clr;
  endtask

  task automatic push_sweep();
    for (int i = 1; i < N; i++) exp_q.push_back('{AW'(i), W'(0)});
  endtask

  // Monitor: every DUT write must match the oldest expected write.
  initial begin
    for (int i = 0; i < N; i++) rf[i] = '0;
    forever begin
      wr_t e;
      @(posedge clk);
      #1;
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(addr_rd), 32'(e.a));
          check("wr_data", 32'(data_in), 32'(e.d));
        end
        rf[addr_rd] = data_in;
      end
    end
  end

  // One SERVE cycle driven from the pending requests.
  task automatic serve_cycle(input string tag);
    int g;
    @(negedge clk);
    apply(1'b0);
    #1;
    g = model_grant(pend[0], pend[1]);
    check({tag, "_ready0"}, 32'(req0_ready), 32'(g == 0));
    check({tag, "_ready1"}, 32'(req1_ready), 32'(g == 1));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (g >= 0) begin
      last_gnt = g;
      if (paddr[g] != '0) exp_q.push_back('{paddr[g], pdata[g]});
      pend[g] = 1'b0;
    end
  endtask

  // Called just after inputs were driven at a negedge inside a sweep; counts
  // busy cycles and checks that no grant escapes. Valids are dropped once
  // busy falls so no unmodelled handshake occurs in that cycle.
  task automatic sweep_wait(input string tag);
    int cnt = 0;
    for (int guard = 0; guard < 100; guard++) begin
      #1;
      if (busy !== 1'b1) break;
      cnt++;
      check({tag, "_readys"}, 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(N - 1));
  endtask

  // Assert reset from the current point, check reset outputs, release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    apply(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_rst_we"}, 32'(we), 32'd0);
    check({tag, "_rst_addr"}, 32'(addr_rd), 32'd0);
    check({tag, "_rst_data"}, 32'(data_in), 32'd0);
    check({tag, "_rst_readys"}, 32'({req0_ready, req1_ready}), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    exp_q.delete();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last_gnt = 1;
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0);
    push_sweep();
    sweep_wait({tag, "_sweep"});
  endtask

  task automatic clear_pulse(input string tag);
    @(negedge clk);
    apply(1'b1);
    #1;
    check({tag, "_clr_readys"}, 32'({req0_ready, req1_ready}), 32'd0);
    check({tag, "_clr_busy"}, 32'(busy), 32'd0);
    push_sweep();
    @(negedge clk);
    apply(1'b0);
  endtask

  task automatic random_traffic(input int cycles);
    repeat (cycles) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom_range(0, N - 1));
          pdata[i] = W'($urandom);
        end
      end
      serve_cycle("rand");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int found;
    rst = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    paddr[0] = '0; paddr[1] = '0;
    pdata[0] = '0; pdata[1] = '0;
    apply(1'b0);
    @(negedge clk);

    // Reset values and the full power-on sweep.
    do_reset("init");

    // Single requester 0 write.
    pend[0] = 1'b1; paddr[0] = AW'(5); pdata[0] = 4'hA;
    serve_cycle("single0");

    // Requester 1 writes register 0: accepted, no write follows.
    pend[1] = 1'b1; paddr[1] = AW'(0); pdata[1] = 4'hF;
    serve_cycle("addr0");

    // Both requesters held valid for four cycles: grants alternate.
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) begin pend[0] = 1'b1; paddr[0] = AW'(3); pdata[0] = W'(k); end
      if (!pend[1]) begin pend[1] = 1'b1; paddr[1] = AW'(7); pdata[1] = W'(k + 8); end
      serve_cycle("both");
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    random_traffic(200);

    // Clear request while both requesters wait; service resumes after.
    pend[0] = 1'b1; paddr[0] = AW'($urandom_range(1, N - 1)); pdata[0] = W'($urandom);
    pend[1] = 1'b1; paddr[1] = AW'($urandom_range(1, N - 1)); pdata[1] = W'($urandom);
    clear_pulse("clr");
    sweep_wait("clr_sweep");
    random_traffic(150);
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Reset in the middle of a sweep at address 12.
    clear_pulse("abort");
    found = 0;
    for (int guard = 0; guard < 100; guard++) begin
      #1;
      if (we === 1'b1 && addr_rd == AW'(12)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_addr12", 32'(found), 32'd1);
    do_reset("abort");
    for (int i = 0; i < N; i++) check($sformatf("rf_zero_%0d", i), 32'(rf[i]), 32'd0);

    random_traffic(50);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    @(negedge clk);
    apply(1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
